// File: rtl/display_ram_arbiter.sv
// display_ram_arbiter: shares the single-port tile RAM between VGA scan-out
// reads (fixed, highest priority) and game-logic writes / full-screen clears.
module display_ram_arbiter #(
  parameter int unsigned TILE_SHIFT = 3,
  parameter int unsigned GRID_W     = 80,
  parameter int unsigned GRID_H     = 60,
  parameter int unsigned AW         = 13,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          DE,
  input  logic [9:0]    ADDRH,
  input  logic [8:0]    ADDRV,
  output logic [7:0]    COLOUR,
  output logic [AW-1:0] RAM_ADDR,
  output logic          RAM_WE,
  output logic [7:0]    RAM_WDATA,
  input  logic [7:0]    RAM_RDATA,
  input  logic          WR_VALID,
  output logic          WR_READY,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [7:0]    WR_DATA,
  input  logic          CLR_REQ,
  input  logic [7:0]    CLR_DATA,
  output logic          CLR_BUSY
);

  localparam int unsigned NTILES = GRID_W * GRID_H;
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = PW + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_entry_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [7:0]      clr_data_q, clr_data_d;
  logic [AW-1:0]   hold_addr_q;
  logic [7:0]      hold_wdata_q;

  wr_entry_t       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  wr_entry_t       head_c;
  logic            full_c, empty_c, head_valid_c;
  logic            push_c, pop_c;

  logic            video_slot_c;
  logic [AW-1:0]   vid_addr_c;
  logic            ram_we_c;
  logic [AW-1:0]   ram_addr_c;
  logic [7:0]      ram_wdata_c;

  logic            de_d1_q, slot_d1_q;
  logic [7:0]      tile_q, colour_q;

  // Video slot: first pixel of each tile during active video; held off in reset
  assign video_slot_c = RESET_N && DE && (ADDRH[TILE_SHIFT-1:0] == '0);
  assign vid_addr_c   = AW'((32'(ADDRV) >> TILE_SHIFT) * GRID_W + (32'(ADDRH) >> TILE_SHIFT));

  // FIFO status and head entry
  assign full_c       = (count_q == CW'(FIFO_DEPTH));
  assign empty_c      = (count_q == '0);
  assign head_c       = fifo_mem[rptr_q];
  assign head_valid_c = (32'(head_c.addr) < NTILES);
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push
  assign push_c       = WR_VALID && (!full_c || pop_c);

  // Next state and RAM port arbitration; video slots override everything
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_data_d  = clr_data_q;
    pop_c       = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = hold_addr_q;
    ram_wdata_c = hold_wdata_q;

    if (video_slot_c) begin
      ram_addr_c = vid_addr_c;
    end

    case (state_q)
      ST_IDLE: begin
        if (CLR_REQ) begin
          state_d    = ST_CLEAR;
          clr_cnt_d  = '0;
          clr_data_d = CLR_DATA;
        end else if (!video_slot_c && !empty_c) begin
          pop_c = 1'b1;
          if (head_valid_c) begin
            ram_we_c    = 1'b1;
            ram_addr_c  = head_c.addr;
            ram_wdata_c = head_c.data;
          end
        end
      end
      ST_CLEAR: begin
        if (!video_slot_c) begin
          ram_we_c    = 1'b1;
          ram_addr_c  = clr_cnt_q;
          ram_wdata_c = clr_data_q;
          clr_cnt_d   = clr_cnt_q + AW'(1);
          if (clr_cnt_q == AW'(NTILES - 1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, sweep counter and held RAM address/data
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      clr_data_q   <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_data_q   <= clr_data_d;
      hold_addr_q  <= ram_addr_c;
      hold_wdata_q <= ram_wdata_c;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_c) wptr_q <= wptr_q + PW'(1);
      if (pop_c)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  // FIFO storage; contents are don't-care until pushed
  always_ff @(posedge CLK) begin
    if (push_c) begin
      fifo_mem[wptr_q] <= '{addr: WR_ADDR, data: WR_DATA};
    end
  end

  // Scan-out pipeline: read data bypasses the tile register so latency stays 2
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      de_d1_q   <= 1'b0;
      slot_d1_q <= 1'b0;
      tile_q    <= '0;
      colour_q  <= '0;
    end else begin
      de_d1_q   <= DE;
      slot_d1_q <= video_slot_c;
      if (slot_d1_q) tile_q <= RAM_RDATA;
      colour_q  <= de_d1_q ? (slot_d1_q ? RAM_RDATA : tile_q) : 8'h00;
    end
  end

  assign COLOUR    = colour_q;
  assign RAM_ADDR  = ram_addr_c;
  assign RAM_WE    = ram_we_c;
  assign RAM_WDATA = ram_wdata_c;
  assign WR_READY  = !full_c;
  assign CLR_BUSY  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_display_ram_arbiter.sv
// Directed bench for display_ram_arbiter with a synchronous RAM model.
module tb_display_ram_arbiter;

  logic        CLK;
  logic        RESET_N;
  logic        DE;
  logic [9:0]  ADDRH;
  logic [8:0]  ADDRV;
  logic [7:0]  COLOUR;
  logic [12:0] RAM_ADDR;
  logic        RAM_WE;
  logic [7:0]  RAM_WDATA;
  logic [7:0]  RAM_RDATA;
  logic        WR_VALID;
  logic        WR_READY;
  logic [12:0] WR_ADDR;
  logic [7:0]  WR_DATA;
  logic        CLR_REQ;
  logic [7:0]  CLR_DATA;
  logic        CLR_BUSY;

  display_ram_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N), .DE(DE), .ADDRH(ADDRH), .ADDRV(ADDRV),
    .COLOUR(COLOUR), .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA),
    .RAM_RDATA(RAM_RDATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .CLR_REQ(CLR_REQ), .CLR_DATA(CLR_DATA),
    .CLR_BUSY(CLR_BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model with one-cycle read latency and a log of every write
  logic [7:0]  mem [8192];
  logic [12:0] log_a [$];
  logic [7:0]  log_d [$];
  int          slot_wr_viol = 0;

  always @(posedge CLK) begin
    RAM_RDATA <= mem[RAM_ADDR];
    if (RAM_WE) begin
      mem[RAM_ADDR] <= RAM_WDATA;
      log_a.push_back(RAM_ADDR);
      log_d.push_back(RAM_WDATA);
      if (DE && (ADDRH[2:0] == 3'd0)) slot_wr_viol <= slot_wr_viol + 1;
    end
  end

  int total  = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passes = passes + 1;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct packed {
    logic        de;
    logic [9:0]  h;
    logic [8:0]  v;
    logic [12:0] addr;
    logic [7:0]  colour;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int base;
    int errs;
    int busy;
    int n;

    // Scan-out vectors: tile 1 holds E0, tile 82 holds 3A
    tbl[0]  = '{1'b1, 10'd8,  9'd0, 13'd1,  8'h00};
    tbl[1]  = '{1'b1, 10'd9,  9'd0, 13'd1,  8'h00};
    tbl[2]  = '{1'b1, 10'd10, 9'd0, 13'd1,  8'hE0};
    tbl[3]  = '{1'b1, 10'd11, 9'd0, 13'd1,  8'hE0};
    tbl[4]  = '{1'b1, 10'd12, 9'd0, 13'd1,  8'hE0};
    tbl[5]  = '{1'b1, 10'd13, 9'd0, 13'd1,  8'hE0};
    tbl[6]  = '{1'b1, 10'd14, 9'd0, 13'd1,  8'hE0};
    tbl[7]  = '{1'b1, 10'd15, 9'd0, 13'd1,  8'hE0};
    tbl[8]  = '{1'b0, 10'd0,  9'd0, 13'd1,  8'hE0};
    tbl[9]  = '{1'b0, 10'd0,  9'd0, 13'd1,  8'hE0};
    tbl[10] = '{1'b0, 10'd0,  9'd0, 13'd1,  8'h00};
    tbl[11] = '{1'b1, 10'd16, 9'd8, 13'd82, 8'h00};
    tbl[12] = '{1'b1, 10'd17, 9'd8, 13'd82, 8'h00};
    tbl[13] = '{1'b0, 10'd0,  9'd0, 13'd82, 8'h3A};
    tbl[14] = '{1'b0, 10'd0,  9'd0, 13'd82, 8'h3A};
    tbl[15] = '{1'b0, 10'd0,  9'd0, 13'd82, 8'h00};

    RESET_N = 1'b0; DE = 1'b0; ADDRH = '0; ADDRV = '0;
    WR_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0; CLR_REQ = 1'b0; CLR_DATA = '0;

    // Reset values
    #12;
    chk("rst_colour", 32'(COLOUR), 32'h0);
    chk("rst_we", 32'(RAM_WE), 32'h0);
    chk("rst_addr", 32'(RAM_ADDR), 32'h0);
    chk("rst_wdata", 32'(RAM_WDATA), 32'h0);
    chk("rst_ready", 32'(WR_READY), 32'h1);
    chk("rst_busy", 32'(CLR_BUSY), 32'h0);
    @(posedge CLK); #1; RESET_N = 1'b1;
    tick();

    // Preload tiles through the write path during blanking
    WR_VALID = 1'b1; WR_ADDR = 13'd1; WR_DATA = 8'hE0; #1;
    chk("pre_ready", 32'(WR_READY), 32'h1);
    tick();
    WR_ADDR = 13'd82; WR_DATA = 8'h3A; #1;
    chk("pre_we0", 32'(RAM_WE), 32'h1);
    chk("pre_addr0", 32'(RAM_ADDR), 32'd1);
    chk("pre_wdata0", 32'(RAM_WDATA), 32'hE0);
    tick();
    WR_VALID = 1'b0; #1;
    chk("pre_addr1", 32'(RAM_ADDR), 32'd82);
    repeat (3) tick();

    // Table-driven scan-out
    for (int i = 0; i < 16; i++) begin
      DE = tbl[i].de; ADDRH = tbl[i].h; ADDRV = tbl[i].v; #1;
      chk($sformatf("scan%0d_we", i), 32'(RAM_WE), 32'h0);
      chk($sformatf("scan%0d_addr", i), 32'(RAM_ADDR), 32'(tbl[i].addr));
      chk($sformatf("scan%0d_colour", i), 32'(COLOUR), 32'(tbl[i].colour));
      tick();
    end

    // Mid-frame reset with writes queued behind continuous video slots
    DE = 1'b1; ADDRH = 10'd8; ADDRV = 9'd0;
    WR_VALID = 1'b1; WR_ADDR = 13'd200; WR_DATA = 8'h77; tick();
    WR_ADDR = 13'd201; WR_DATA = 8'h78; tick();
    WR_VALID = 1'b0; tick();
    chk("mf_colour_pre", 32'(COLOUR), 32'hE0);
    base = log_a.size();
    RESET_N = 1'b0; #1;
    chk("mf_colour", 32'(COLOUR), 32'h0);
    chk("mf_addr", 32'(RAM_ADDR), 32'h0);
    chk("mf_we", 32'(RAM_WE), 32'h0);
    chk("mf_wdata", 32'(RAM_WDATA), 32'h0);
    chk("mf_ready", 32'(WR_READY), 32'h1);
    tick();
    RESET_N = 1'b1; ADDRH = 10'd24; ADDRV = 9'd16; #1;
    chk("mf_first_slot", 32'(RAM_ADDR), 32'd163);
    tick();
    DE = 1'b0;
    repeat (5) tick();
    chk("mf_queue_lost", 32'(log_a.size() - base), 32'd0);

    // Fill the FIFO while every cycle is a video slot, then push+pop when full
    DE = 1'b1; ADDRH = 10'd0; ADDRV = 9'd0;
    for (int i = 0; i < 4; i++) begin
      WR_VALID = 1'b1; WR_ADDR = 13'(100 + i); WR_DATA = 8'(16 + i); #1;
      chk($sformatf("ff_ready%0d", i), 32'(WR_READY), 32'h1);
      chk($sformatf("ff_noslotwr%0d", i), 32'(RAM_WE), 32'h0);
      tick();
    end
    WR_VALID = 1'b0; #1;
    chk("ff_full", 32'(WR_READY), 32'h0);
    tick();
    ADDRH = 10'd1; WR_VALID = 1'b1; WR_ADDR = 13'd104; WR_DATA = 8'd20; #1;
    chk("ff_pp_we", 32'(RAM_WE), 32'h1);
    chk("ff_pp_addr", 32'(RAM_ADDR), 32'd100);
    chk("ff_pp_wdata", 32'(RAM_WDATA), 32'd16);
    tick();
    ADDRH = 10'd0; WR_VALID = 1'b0; #1;
    chk("ff_still_full", 32'(WR_READY), 32'h0);
    chk("ff_slot_we", 32'(RAM_WE), 32'h0);
    tick();
    DE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ff_drain%0d_addr", i), 32'(RAM_ADDR), 32'(101 + i));
      chk($sformatf("ff_drain%0d_wdata", i), 32'(RAM_WDATA), 32'(17 + i));
      tick();
    end
    chk("ff_ready_after", 32'(WR_READY), 32'h1);

    // Five back-to-back pushes during stepping active video
    base = log_a.size();
    for (int c = 0; c < 20; c++) begin
      DE = 1'b1; ADDRH = 10'(c); ADDRV = 9'd0;
      WR_VALID = (c < 5); WR_ADDR = 13'(300 + c); WR_DATA = 8'(c + 8'h50);
      tick();
    end
    WR_VALID = 1'b0; DE = 1'b0;
    repeat (3) tick();
    chk("av_count", 32'(log_a.size() - base), 32'd5);
    errs = 0;
    for (int i = 0; i < 5; i++)
      if (log_a.size() > base + i)
        if (log_a[base + i] != 13'(300 + i) || log_d[base + i] != 8'(i + 8'h50)) errs++;
    chk("av_order", 32'(errs), 32'd0);

    // Out-of-range address is discarded
    base = log_a.size();
    WR_VALID = 1'b1; WR_ADDR = 13'd4800; WR_DATA = 8'h55; tick();
    WR_ADDR = 13'd5; WR_DATA = 8'h66; #1;
    chk("disc_we", 32'(RAM_WE), 32'h0);
    tick();
    WR_VALID = 1'b0; #1;
    chk("disc_next_addr", 32'(RAM_ADDR), 32'd5);
    tick();
    chk("disc_count", 32'(log_a.size() - base), 32'd1);

    // Clear during blanking with two writes queued
    WR_VALID = 1'b1; WR_ADDR = 13'd400; WR_DATA = 8'h40; tick();
    WR_ADDR = 13'd401; WR_DATA = 8'h41; CLR_REQ = 1'b1; CLR_DATA = 8'h1C; #1;
    chk("clr_pop_blocked", 32'(RAM_WE), 32'h0);
    tick();
    WR_VALID = 1'b0; CLR_REQ = 1'b0;
    base = log_a.size();
    busy = 0;
    for (n = 0; n < 6000; n++) begin
      CLR_REQ = (n == 100); CLR_DATA = (n == 100) ? 8'h99 : 8'h1C; #1;
      if (!CLR_BUSY) break;
      busy++;
      tick();
    end
    CLR_REQ = 1'b0;
    chk("clr_busy_cycles", 32'(busy), 32'd4800);
    repeat (4) tick();
    chk("clr_count", 32'(log_a.size() - base), 32'd4802);
    errs = 0;
    for (int i = 0; i < 4800; i++)
      if (log_a.size() > base + i)
        if (log_a[base + i] != 13'(i) || log_d[base + i] != 8'h1C) errs++;
    chk("clr_sweep", 32'(errs), 32'd0);
    if (log_a.size() >= base + 4802) begin
      chk("clr_q0", {log_a[base + 4800], log_d[base + 4800]}, {13'd400, 8'h40});
      chk("clr_q1", {log_a[base + 4801], log_d[base + 4801]}, {13'd401, 8'h41});
    end else begin
      chk("clr_queued_present", 32'(log_a.size() - base), 32'd4802);
    end

    // Reset in the middle of a sweep, then restart
    CLR_REQ = 1'b1; CLR_DATA = 8'h5A; tick();
    CLR_REQ = 1'b0;
    base = log_a.size();
    for (n = 0; n < 3000 && (log_a.size() - base) < 2000; n++) tick();
    #1;
    chk("mc_at2000_addr", 32'(RAM_ADDR), 32'd2000);
    chk("mc_at2000_we", 32'(RAM_WE), 32'h1);
    RESET_N = 1'b0; #1;
    chk("mc_busy", 32'(CLR_BUSY), 32'h0);
    chk("mc_we", 32'(RAM_WE), 32'h0);
    tick();
    RESET_N = 1'b1;
    base = log_a.size();
    repeat (10) tick();
    chk("mc_no_writes", 32'(log_a.size() - base), 32'd0);
    CLR_REQ = 1'b1; CLR_DATA = 8'h66; tick();
    CLR_REQ = 1'b0; #1;
    chk("mc_restart_busy", 32'(CLR_BUSY), 32'h1);
    chk("mc_restart_addr", 32'(RAM_ADDR), 32'd0);
    chk("mc_restart_wdata", 32'(RAM_WDATA), 32'h66);
    tick();
    #1;
    chk("mc_restart_addr1", 32'(RAM_ADDR), 32'd1);

    chk("slot_write_overlap", 32'(slot_wr_viol), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
